// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared definitions for the RAM BIST controller.
//   state_t     : march controller states.
//   DEF_PATTERN : default base test pattern (8 bits).
//   depth_of()  : number of RAM words for a given address width.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR0   = 3'd1,
        RD0   = 3'd2,
        WR1   = 3'd3,
        RD1   = 3'd4,
        DRAIN = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic [7:0] DEF_PATTERN = 8'hA5;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if
// Single-port synchronous RAM bus between the BIST controller and the RAM.
//   ram_we    : write enable (write occurs at the clock edge where it is high)
//   ram_addr  : word address
//   ram_wdata : write data
//   ram_rdata : registered read data, one cycle after a read edge
// Modports: master = BIST controller, slave = RAM.
interface ram_bist_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_bist_checker.sv
// ram_bist_checker
// Compare pipeline for the RAM BIST. A read issued in one cycle is compared
// against its expected value in the next cycle, when the RAM's registered
// read data is valid. The first mismatch is captured and signalled.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : clear captured failure (new test accepted)
//   issue       : a read is being issued this cycle
//   issue_addr  : address of the issued read
//   issue_exp   : value expected back from that read
//   rdata       : RAM registered read data
//   fail        : mismatch detected this cycle (combinational)
//   fail_addr   : address of the captured mismatch
//   fail_data   : data read at fail_addr
module ram_bist_checker #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_exp,
    input  logic [DATA_W-1:0] rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] exp_p1;

    assign fail = vld_p1 && (rdata != exp_p1);

    // p0 -> p1: issued read travels alongside its expected value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            exp_p1    <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            // A read in flight when a mismatch aborts the test is discarded.
            vld_p1  <= issue && !fail;
            addr_p1 <= issue_addr;
            exp_p1  <= issue_exp;
            if (clr) begin
                fail_addr <= '0;
                fail_data <= '0;
            end else if (fail) begin
                fail_addr <= addr_p1;
                fail_data <= rdata;
            end
        end
    end

endmodule

// File: rtl/ram_bist.sv
// ram_bist
// Built-in self-test controller for a single-port synchronous RAM. On a start
// pulse it runs a march: write P(a) to all words, read/compare them, write
// ~P(a) to all words, read/compare them, then one drain cycle for the last
// compare. P(a) = PATTERN ^ a. The first mismatch aborts the test.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle request, ignored while busy
//   busy       : test phases running
//   done       : test finished, held until next accepted start
//   pass       : valid with done, 1 = no mismatch
//   fail_addr  : first failing address
//   fail_data  : data read at fail_addr
//   ram        : RAM bus (master side)
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    ram_bist_if.master        ram
);

    localparam int unsigned       DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              pass_q;
    logic              accept;
    logic              rd_issue;
    logic [DATA_W-1:0] rd_exp;
    logic              fail_pulse;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return PATTERN ^ DATA_W'(a);
    endfunction

    assign accept   = start && (state == IDLE || state == FIN);
    assign rd_issue = (state == RD0) || (state == RD1);
    assign rd_exp   = (state == RD1) ? ~pat(addr_q) : pat(addr_q);

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);
    assign pass = pass_q;

    // RAM drive depends only on registered state and counter.
    always_comb begin
        ram.ram_we    = 1'b0;
        ram.ram_addr  = '0;
        ram.ram_wdata = '0;
        case (state)
            WR0: begin
                ram.ram_we    = 1'b1;
                ram.ram_addr  = addr_q;
                ram.ram_wdata = pat(addr_q);
            end
            WR1: begin
                ram.ram_we    = 1'b1;
                ram.ram_addr  = addr_q;
                ram.ram_wdata = ~pat(addr_q);
            end
            RD0, RD1: ram.ram_addr = addr_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state  <= WR0;
                        addr_q <= '0;
                        pass_q <= 1'b0;
                    end
                end
                WR0, RD0, WR1, RD1: begin
                    if (fail_pulse) begin
                        state  <= FIN;
                        addr_q <= '0;
                        pass_q <= 1'b0;
                    end else begin
                        // Counter wraps to 0 on its own at the phase change.
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == LAST) begin
                            case (state)
                                WR0:     state <= RD0;
                                RD0:     state <= WR1;
                                WR1:     state <= RD1;
                                default: state <= DRAIN;
                            endcase
                        end
                    end
                end
                DRAIN: begin
                    state  <= FIN;
                    pass_q <= !fail_pulse;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_bist_checker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept),
        .issue      (rd_issue),
        .issue_addr (addr_q),
        .issue_exp  (rd_exp),
        .rdata      (ram.ram_rdata),
        .fail       (fail_pulse),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data)
    );

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist
// Self-checking bench for ram_bist: a RAM model with injectable stuck-at bits
// and a word-level reference model of the march outcome.
module tb_ram_bist;

    localparam int         AW    = 4;
    localparam int         DW    = 8;
    localparam int         DEPTH = 16;
    localparam logic [7:0] PAT   = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    int total = 0;
    int bad   = 0;

    ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(PAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .ram       (rif.master)
    );

    always #5 clk = ~clk;

    // RAM model with stuck-at-1 / stuck-at-0 masks per word
    logic [7:0] mem [DEPTH];
    logic [7:0] st1 [DEPTH];
    logic [7:0] st0 [DEPTH];
    logic [7:0] rdata_q = 8'h00;

    always @(posedge clk) begin
        if (rif.ram_we)
            mem[rif.ram_addr] <= (rif.ram_wdata | st1[rif.ram_addr]) & ~st0[rif.ram_addr];
        else
            rdata_q <= mem[rif.ram_addr];
    end
    assign rif.ram_rdata = rdata_q;

    function automatic logic [7:0] pat_of(input int a, input int ph);
        logic [7:0] p;
        p = PAT ^ 8'(a);
        return (ph != 0) ? ~p : p;
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            st1[i] = 8'h00;
            st0[i] = 8'h00;
            mem[i] = 8'h00;
        end
    endtask

    // Reference: walk both phases word by word; first word whose stored value
    // differs from what was written decides the outcome and the run length.
    task automatic model_run(output bit e_pass, output int e_busy,
                             output logic [AW-1:0] e_fa, output logic [DW-1:0] e_fd);
        logic [7:0] w;
        logic [7:0] s;
        e_pass = 1'b1;
        e_busy = 4 * DEPTH + 1;
        e_fa   = '0;
        e_fd   = '0;
        for (int ph = 0; ph < 2 && e_pass; ph++) begin
            for (int a = 0; a < DEPTH && e_pass; a++) begin
                w = pat_of(a, ph);
                s = (w | st1[a]) & ~st0[a];
                if (s != w) begin
                    e_pass = 1'b0;
                    e_fa   = AW'(a);
                    e_fd   = s;
                    // writes, reads up to a, then one compare cycle
                    e_busy = ph * 2 * DEPTH + DEPTH + a + 2;
                end
            end
        end
    endtask

    // Pulse start, follow the run cycle by cycle and check the outcome.
    task automatic run_check(input string name, input int start_at);
        bit         e_pass;
        int         e_busy;
        logic [AW-1:0] e_fa;
        logic [DW-1:0] e_fd;
        int         cyc;
        int         ph4;
        int         a;
        logic       x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        model_run(e_pass, e_busy, e_fa, e_fd);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            if (cyc <= 4 * DEPTH) begin
                ph4    = (cyc - 1) / DEPTH;
                a      = (cyc - 1) % DEPTH;
                x_we   = (ph4 % 2) == 0;
                x_addr = AW'(a);
                x_wd   = x_we ? pat_of(a, ph4 / 2) : 8'h00;
            end else begin
                x_we   = 1'b0;
                x_addr = '0;
                x_wd   = '0;
            end
            total++;
            if (rif.ram_we !== x_we || rif.ram_addr !== x_addr || rif.ram_wdata !== x_wd) begin
                bad++;
                $display("FAIL %s ram_bus cycle %0d: got we=%b addr=%0d wdata=%h, want we=%b addr=%0d wdata=%h",
                         name, cyc, rif.ram_we, rif.ram_addr, rif.ram_wdata, x_we, x_addr, x_wd);
            end
            if (cyc == 4) begin
                total++;
                if (rif.ram_wdata !== 8'hA6) begin
                    bad++;
                    $display("FAIL %s wr0_addr3: got %h want a6", name, rif.ram_wdata);
                end
            end
            if (cyc == 36) begin
                total++;
                if (rif.ram_wdata !== 8'h59) begin
                    bad++;
                    $display("FAIL %s wr1_addr3: got %h want 59", name, rif.ram_wdata);
                end
            end
            start = (cyc == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (cyc >= 300) begin
            bad++;
            $display("FAIL %s timeout: busy still high after %0d cycles", name, cyc);
            return;
        end
        if (cyc != e_busy) begin
            bad++;
            $display("FAIL %s busy_len: got %0d want %0d", name, cyc, e_busy);
        end
        total++;
        if (done !== 1'b1 || pass !== e_pass) begin
            bad++;
            $display("FAIL %s result: got done=%b pass=%b want done=1 pass=%b", name, done, pass, e_pass);
        end
        if (!e_pass) begin
            total++;
            if (fail_addr !== e_fa || fail_data !== e_fd) begin
                bad++;
                $display("FAIL %s capture: got addr=%0d data=%h want addr=%0d data=%h",
                         name, fail_addr, fail_data, e_fa, e_fd);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_addr !== '0 ||
            fail_data !== '0 || rif.ram_we !== 1'b0 || rif.ram_addr !== '0 || rif.ram_wdata !== '0) begin
            bad++;
            $display("FAIL %s idle_outputs: busy=%b done=%b pass=%b fa=%0d fd=%h we=%b addr=%0d wd=%h, want all 0",
                     name, busy, done, pass, fail_addr, fail_data, rif.ram_we, rif.ram_addr, rif.ram_wdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_pass_run();
        clear_faults();
        run_check("pass_run", -1);
    endtask

    task automatic test_stuck_bit();
        clear_faults();
        st1[5] = 8'h01;
        run_check("stuck_bit", -1);
        total++;
        if (fail_addr !== 4'd5 || fail_data !== 8'hA1) begin
            bad++;
            $display("FAIL stuck_bit literal: got addr=%0d data=%h want addr=5 data=a1", fail_addr, fail_data);
        end
    endtask

    task automatic test_complement_fault();
        clear_faults();
        st1[15] = 8'h80;
        run_check("complement_fault", -1);
    endtask

    task automatic test_start_while_busy();
        clear_faults();
        run_check("start_while_busy", 10);
    endtask

    task automatic test_reset_mid();
        clear_faults();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rif.ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rif.ram_addr !== '0) begin
            bad++;
            $display("FAIL reset_mid async: got we=%b busy=%b done=%b addr=%0d want 0",
                     rif.ram_we, busy, done, rif.ram_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_mid_after");
        run_check("reset_mid_rerun", -1);
    endtask

    task automatic test_back_to_back();
        int n;
        clear_faults();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back precondition: done=%b want 1", done);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || rif.ram_we !== 1'b1 || rif.ram_addr !== '0) begin
            bad++;
            $display("FAIL back_to_back first_cycle: done=%b busy=%b we=%b addr=%0d want 0 1 1 0",
                     done, busy, rif.ram_we, rif.ram_addr);
        end
        n = 1;
        while (busy && n < 300) begin
            @(negedge clk);
            if (busy) n++;
        end
        total++;
        if (n != 4 * DEPTH + 1 || done !== 1'b1 || pass !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back run: busy_len=%0d done=%b pass=%b want 65 1 1", n, done, pass);
        end
    endtask

    task automatic test_random();
        int nf;
        int fa;
        int fb;
        for (int it = 0; it < 10; it++) begin
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int k = 0; k < nf; k++) begin
                fa = $urandom_range(0, DEPTH - 1);
                fb = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) st1[fa][fb] = 1'b1;
                else                           st0[fa][fb] = 1'b1;
            end
            run_check($sformatf("random%0d", it), $urandom_range(0, 1) == 1 ? $urandom_range(2, 60) : -1);
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_pass_run();
        test_stuck_bit();
        test_complement_fault();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
